// File: rtl/mod_ram_dp_pkg.sv
// mod_ram_dp_pkg -- shared types and default sizing for the dual-port RAM.
//   state_t    : controller state (CLEAR wipes memory, RUN serves requests)
//   DEF_ADDR_W : default word-address width (depth = 2**DEF_ADDR_W words)
//   DEF_DATA_W : default word width in bits (multiple of 8)
package mod_ram_dp_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mod_ram_dp_inferred_ram_be.sv
// inferred_ram_be -- true dual-port, byte-write, synchronous-read RAM written
// in the shape synthesis maps onto block RAM.
//   clk            : single clock
//   a_en / b_en    : port enable (read and/or write this cycle)
//   a_we / b_we    : per-byte write enables
//   a_addr/b_addr  : word address
//   a_din / b_din  : write data
//   a_dout/b_dout  : registered read data (old contents on a same-port write)
// Both ports share one process so the array has a single driver; if both
// ports write the same byte in one cycle, port b wins. Outputs carry no reset
// so the read register can be absorbed into the RAM primitive.
module inferred_ram_be
    import mod_ram_dp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                a_en,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    input  logic                b_en,
    input  logic [DATA_W/8-1:0] b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_din,
    output logic [DATA_W-1:0]   b_dout
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
            for (int k = 0; k < BE_W; k++) begin
                if (a_we[k]) mem[a_addr][k*8 +: 8] <= a_din[k*8 +: 8];
            end
        end
        if (b_en) begin
            b_dout <= mem[b_addr];
            for (int k = 0; k < BE_W; k++) begin
                if (b_we[k]) mem[b_addr][k*8 +: 8] <= b_din[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mod_ram_dp.sv
// mod_ram_dp -- instruction/data dual-port memory with byte writes.
//   clk, rst_n                : clock, asynchronous active-low reset
//   ie, iaddr -> iout, ivalid : instruction read port (address wraps)
//   de, drw, daddr, dbe, din  : data port request (drw=1 write, 0 read)
//   dout, dvalid              : data read result, one cycle after request
//   derr                      : one-cycle pulse for an out-of-range daddr
//   ready                     : requests are accepted this cycle
// Build option MOD_RAM_DP_CLEAR_EN: after reset the memory is zeroed one word
// per cycle (ready low) before entering RUN. Without it the controller sits
// in RUN and contents are uninitialised.
// Handshake: a request is taken on a rising edge where its enable and ready
// are both 1; otherwise it is ignored. Read data and its valid appear the
// following cycle; data outputs read zero whenever their valid is low.
module mod_ram_dp
    import mod_ram_dp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ie,
    input  logic [31:0]         iaddr,
    output logic [DATA_W-1:0]   iout,
    output logic                ivalid,
    input  logic                de,
    input  logic                drw,
    input  logic [31:0]         daddr,
    input  logic [DATA_W/8-1:0] dbe,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dvalid,
    output logic                derr,
    output logic                ready
);

    localparam int BE_W = DATA_W / 8;
    localparam int L    = $clog2(BE_W);

    state_t              state_q, state_d;
    logic                clearing;
    logic [ADDR_W-1:0]   clr_addr;

    logic [ADDR_W-1:0]   iword, dword;
    logic                d_in_range;
    logic                i_acc, d_acc, d_rd, d_wr, d_oob;
    logic [DATA_W-1:0]   a_dout, b_dout;
    logic                ivalid_q, dvalid_q, derr_q;
    logic [BE_W-1:0]     byp_be_q;
    logic [DATA_W-1:0]   byp_data_q;
    logic [DATA_W-1:0]   iout_merged;
    logic                unused_addr;

    // ---------------------------------------------------------------- control
`ifdef MOD_RAM_DP_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        clearing = 1'b0;
        clr_addr = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clearing = 1'b1;
                if (clr_cnt_q == ADDR_W'((1 << ADDR_W) - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign ready = (state_q == RUN);
`else
    logic ready_q;

    // ready_q holds ready low while reset is asserted and rises on the first
    // edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = RUN;
        clearing = 1'b0;
        clr_addr = '0;
    end

    assign ready = ready_q && (state_q == RUN);
`endif

    // --------------------------------------------------------------- decode
    assign iword       = iaddr[ADDR_W+L-1:L];
    assign dword       = daddr[ADDR_W+L-1:L];
    assign d_in_range  = ((daddr >> (ADDR_W + L)) == 32'd0);
    assign unused_addr = ^{iaddr, daddr};

    assign i_acc = ie && ready;
    assign d_acc = de && ready && d_in_range;
    assign d_oob = de && ready && !d_in_range;
    assign d_rd  = d_acc && !drw;
    assign d_wr  = d_acc && drw;

    // ------------------------------------------------------------- storage
    // Port a serves instruction reads; port b serves data accesses and the
    // clear sequence (ready is low while clearing, so they never collide).
    inferred_ram_be #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .a_en   (i_acc),
        .a_we   ('0),
        .a_addr (iword),
        .a_din  ('0),
        .a_dout (a_dout),
        .b_en   (clearing || d_acc),
        .b_we   (clearing ? {BE_W{1'b1}} : (d_wr ? dbe : '0)),
        .b_addr (clearing ? clr_addr : dword),
        .b_din  (clearing ? '0 : din),
        .b_dout (b_dout)
    );

    // ------------------------------------------------------------- outputs
    // The RAM returns old data on a cross-port collision, so the written
    // bytes are captured here and overlaid on the instruction read result
    // to give write-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivalid_q   <= 1'b0;
            dvalid_q   <= 1'b0;
            derr_q     <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            ivalid_q   <= i_acc;
            dvalid_q   <= d_rd;
            derr_q     <= d_oob;
            byp_be_q   <= (i_acc && d_wr && (iword == dword)) ? dbe : '0;
            byp_data_q <= din;
        end
    end

    always_comb begin
        iout_merged = a_dout;
        for (int k = 0; k < BE_W; k++) begin
            if (byp_be_q[k]) iout_merged[k*8 +: 8] = byp_data_q[k*8 +: 8];
        end
    end

    assign iout   = ivalid_q ? iout_merged : '0;
    assign ivalid = ivalid_q;
    assign dout   = dvalid_q ? b_dout : '0;
    assign dvalid = dvalid_q;
    assign derr   = derr_q;

endmodule

// File: tb/tb_mod_ram_dp.sv
// tb_mod_ram_dp -- directed test of mod_ram_dp at ADDR_W=4 (16 words,
// byte addresses 0x00..0x3F). Works with and without MOD_RAM_DP_CLEAR_EN.
module tb_mod_ram_dp;

`ifdef MOD_RAM_DP_CLEAR_EN
    localparam int  CLR_CYCLES = 16;
    localparam bit  CLEARS     = 1'b1;
`else
    localparam int  CLR_CYCLES = 1;
    localparam bit  CLEARS     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ie, de, drw;
    logic [31:0] iaddr, daddr, din;
    logic [3:0]  dbe;
    logic [31:0] iout, dout;
    logic        ivalid, dvalid, derr, ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mod_ram_dp #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ie     (ie),
        .iaddr  (iaddr),
        .iout   (iout),
        .ivalid (ivalid),
        .de     (de),
        .drw    (drw),
        .daddr  (daddr),
        .dbe    (dbe),
        .din    (din),
        .dout   (dout),
        .dvalid (dvalid),
        .derr   (derr),
        .ready  (ready)
    );

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ checker
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic d_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        de = 1'b1; drw = 1'b1; daddr = a; din = d; dbe = be;
        tick();
        de = 1'b0; drw = 1'b0; dbe = '0;
    endtask

    task automatic d_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        de = 1'b1; drw = 1'b0; daddr = a;
        exp_q.push_back(exp);
        tick();
        de = 1'b0;
        check_eq({tag, "_dvalid"}, 32'(dvalid), 32'd1);
        check_eq({tag, "_dout"}, dout, exp_q.pop_front());
    endtask

    task automatic i_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        ie = 1'b1; iaddr = a;
        exp_q.push_back(exp);
        tick();
        ie = 1'b0;
        check_eq({tag, "_ivalid"}, 32'(ivalid), 32'd1);
        check_eq({tag, "_iout"}, iout, exp_q.pop_front());
    endtask

    // Counts cycles from reset release until ready rises (bounded).
    task automatic wait_ready(input string tag);
        int n = 0;
        rst_n = 1'b1;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n), 32'(CLR_CYCLES));
    endtask

    // ----------------------------------------------------------- sequence
    initial begin
        rst_n = 1'b0;
        ie = 1'b0; de = 1'b0; drw = 1'b0;
        iaddr = '0; daddr = '0; din = '0; dbe = '0;
        repeat (3) tick();

        check_eq("rst_ready",  32'(ready),  32'd0);
        check_eq("rst_ivalid", 32'(ivalid), 32'd0);
        check_eq("rst_dvalid", 32'(dvalid), 32'd0);
        check_eq("rst_derr",   32'(derr),   32'd0);
        check_eq("rst_iout",   iout,        32'd0);
        check_eq("rst_dout",   dout,        32'd0);

        // Reset asserted five cycles into the clear sequence restarts it.
        rst_n = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_eq("midclr_ready", 32'(ready), 32'd0);
        wait_ready("clear_cycles");

        // Idle cycle: nothing requested, so both result ports read zero.
        check_eq("idle_ivalid", 32'(ivalid), 32'd0);
        check_eq("idle_iout",   iout,        32'd0);

        if (CLEARS) begin
            d_read("clr_w0",  32'h00, 32'h0);
            d_read("clr_w15", 32'h3C, 32'h0);
            i_read("clr_w7",  32'h1C, 32'h0);
        end

        // Partial byte write onto a zeroed word.
        d_write(32'h08, 32'h0000_0000, 4'hF);
        d_write(32'h08, 32'hDEAD_BEEF, 4'b0011);
        check_eq("wr_dvalid", 32'(dvalid), 32'd0);
        d_read("be_lo", 32'h08, 32'h0000_BEEF);

        // dbe=0 write changes nothing and raises no error.
        d_write(32'h08, 32'hFFFF_FFFF, 4'h0);
        check_eq("be0_derr", 32'(derr), 32'd0);
        d_read("be0", 32'h0B, 32'h0000_BEEF);

        // Same-cycle instruction read and data write: full and partial merge.
        d_write(32'h10, 32'hAAAA_AAAA, 4'hF);
        d_write(32'h14, 32'h1122_3344, 4'hF);
        ie = 1'b1; iaddr = 32'h10;
        de = 1'b1; drw = 1'b1; daddr = 32'h10; din = 32'h1234_5678; dbe = 4'hF;
        tick();
        ie = 1'b0; de = 1'b0; drw = 1'b0; dbe = '0;
        check_eq("wf_full_ivalid", 32'(ivalid), 32'd1);
        check_eq("wf_full_iout",   iout,        32'h1234_5678);
        ie = 1'b1; iaddr = 32'h14;
        de = 1'b1; drw = 1'b1; daddr = 32'h14; din = 32'hCAFE_0000; dbe = 4'b1100;
        tick();
        ie = 1'b0; de = 1'b0; drw = 1'b0; dbe = '0;
        check_eq("wf_part_iout", iout, 32'hCAFE_3344);
        d_read("wf_part_mem", 32'h14, 32'hCAFE_3344);

        // Both ports reading in the same cycle.
        ie = 1'b1; iaddr = 32'h10;
        de = 1'b1; drw = 1'b0; daddr = 32'h14;
        tick();
        ie = 1'b0; de = 1'b0;
        check_eq("dual_iout", iout, 32'h1234_5678);
        check_eq("dual_dout", dout, 32'hCAFE_3344);

        // Out-of-range data read: error pulse, no data.
        de = 1'b1; drw = 1'b0; daddr = 32'h40;
        tick();
        de = 1'b0;
        check_eq("oob_rd_derr",   32'(derr),   32'd1);
        check_eq("oob_rd_dvalid", 32'(dvalid), 32'd0);
        check_eq("oob_rd_dout",   dout,        32'd0);
        tick();
        check_eq("oob_rd_derr_end", 32'(derr), 32'd0);

        // Out-of-range write aliasing word 2 must be suppressed.
        d_write(32'h48, 32'hFFFF_FFFF, 4'hF);
        check_eq("oob_wr_derr", 32'(derr), 32'd1);
        d_read("oob_wr_mem", 32'h08, 32'h0000_BEEF);

        // Instruction address wraps with no error.
        i_read("iwrap", 32'h0000_0048, 32'h0000_BEEF);
        check_eq("iwrap_derr", 32'(derr), 32'd0);

        // Reset during an in-flight read: no valid follows.
        ie = 1'b1; iaddr = 32'h08;
        #1 rst_n = 1'b0;
        tick();
        ie = 1'b0;
        check_eq("rst_drop_ivalid", 32'(ivalid), 32'd0);
        check_eq("rst_drop_iout",   iout,        32'd0);
        wait_ready("clear_cycles2");
        d_read("retain", 32'h08, CLEARS ? 32'h0 : 32'h0000_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_ram_dp.md
MOD_RAM_DP -- requirements
Module: mod_ram_dp

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning word-address bits; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; a multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all logic rises on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port ie  in  1  meaning instruction-port read request.
REQ-006 SHALL have port iaddr  in  32  meaning instruction byte address.
REQ-007 SHALL have port iout  out  DATA_W  meaning instruction read data.
REQ-008 SHALL have port ivalid  out  1  meaning iout holds valid data.
REQ-009 SHALL have port de  in  1  meaning data-port request.
REQ-010 SHALL have port drw  in  1  meaning 1 = write, 0 = read.
REQ-011 SHALL have port daddr  in  32  meaning data byte address.
REQ-012 SHALL have port dbe  in  BE_W  meaning byte write enables.
REQ-013 SHALL have port din  in  DATA_W  meaning write data.
REQ-014 SHALL have port dout  out  DATA_W  meaning data read data.
REQ-015 SHALL have port dvalid  out  1  meaning dout holds valid data.
REQ-016 SHALL have port derr  out  1  meaning one-cycle out-of-range pulse.
REQ-017 SHALL have port ready  out  1  meaning requests are accepted this cycle.

Function
REQ-018 Word index SHALL be addr[ADDR_W+L-1:L], L = log2(BE_W); bits below L ignored.
REQ-019 A request SHALL be accepted only when its enable and ready are both 1; otherwise ignored.
REQ-020 Read latency SHALL be one cycle: ivalid/dvalid high the cycle after an accepted read, else low.
REQ-021 iout/dout SHALL be all-zero whenever the matching valid is 0.
REQ-022 Accepted write SHALL update only bytes with dbe[k]=1; dvalid stays 0 for writes.
REQ-023 dbe = 0 write SHALL leave memory unchanged, with no error raised.
REQ-024 Same-cycle instruction read and data write to one word SHALL return the merged new data (write-first).
REQ-025 daddr bits above ADDR_W+L-1 nonzero SHALL suppress the access and pulse derr the next cycle.
REQ-026 On an out-of-range data read, dvalid SHALL stay 0.
REQ-027 iaddr upper bits SHALL be ignored (wraps modulo depth); no error raised.
REQ-028 Both ports SHALL operate independently and concurrently in every cycle that ready=1.

Reset
REQ-029 While rst_n=0: iout=0, dout=0, ivalid=0, dvalid=0, derr=0, ready=0; state = CLEAR (macro) or RUN (no macro).
REQ-030 Reset assertion mid-operation SHALL drop in-flight reads; no valid pulse follows. Memory contents are retained unless the clear sequence reruns.

Configuration
REQ-031 Macro MOD_RAM_DP_CLEAR_EN defined: the FSM SHALL include CLEAR and RUN states.
REQ-032 In CLEAR, the counter SHALL write zero to word 0..depth-1, one per cycle, with ready=0.
REQ-033 After writing the last word, the FSM SHALL go to RUN with ready=1.
REQ-034 Clear SHALL take exactly 2^ADDR_W cycles after reset release; reset during clear restarts at word 0.
REQ-035 Macro undefined: the FSM SHALL be RUN only; ready=1 from the first cycle after reset release; contents uninitialised.

Structure
REQ-036 Package mod_ram_dp_pkg SHALL hold the state enum {CLEAR, RUN} and default ADDR_W/DATA_W constants.
REQ-037 Storage SHALL be sub-module inferred_ram_be: true dual-port, byte-write, synchronous-read, inferable as block RAM.

Verification
REQ-038 Macro on, ADDR_W=4: release reset -> ready=0 for 16 cycles, then 1; a read of any word returns 0.
REQ-039 Write daddr=0x8, din=0xDEADBEEF, dbe=4'b0011; then read 0x8 -> dout=0x0000BEEF, dvalid=1, one cycle after.
REQ-040 Same cycle: write 0x10=0x12345678, dbe=4'hF, with ie=1, iaddr=0x10 -> next cycle iout=0x12345678.
REQ-041 ADDR_W=4, read daddr=0x40 -> derr=1 for one cycle, dvalid=0, dout=0; memory unchanged.
REQ-042 Assert rst_n=0 at clear counter 5, release -> 16 more clear cycles before ready=1.
REQ-043 Macro off: ready=1 the first cycle after reset; ie=0 -> iout=0, ivalid=0.
